// File: rtl/tt_um_serial_subtractor.sv
// Bit-serial subtractor tile: byte-wide operand load, LSB-first serial
// difference through a registered borrow. Optional ADD_MODE_EN adds a per-operation add mode.
module tt_um_serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [WIDTH-1:0] a_reg, b_reg, res_reg, out_reg;
    logic [WIDTH-1:0] res_shifted;
    logic [CNT_W-1:0] cnt_reg;
    logic             br_reg, br_next, d;
    logic             busy_reg, done_reg, borrow_reg, zero_reg;
    logic             load_a, load_b, start, any_load, last_bit;
    logic             load_en, start_go, shift_en, finish_en;
    logic             a0, b0;
    logic             unused;

    assign load_a   = uio_in[0];
    assign load_b   = uio_in[1];
    assign start    = uio_in[2];
    assign any_load = load_a | load_b;
    assign last_bit = (cnt_reg == CNT_LAST);
    assign a0       = a_reg[0];
    assign b0       = b_reg[0];

    // Upper operand bits (WIDTH<8) and the spare control bits are intentionally dropped.
    assign unused = &{1'b0, ui_in, uio_in};

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else if (ena) begin
            state_reg <= state_next;
        end
    end

    // FSM: next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start && !any_load) state_next = SHIFT;
            SHIFT:   if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM: per-state datapath controls (a load in the same cycle wins over start)
    always_comb begin
        load_en   = 1'b0;
        start_go  = 1'b0;
        shift_en  = 1'b0;
        finish_en = 1'b0;
        case (state_reg)
            IDLE: begin
                load_en  = any_load;
                start_go = start && !any_load;
            end
            SHIFT:   shift_en  = 1'b1;
            DONE:    finish_en = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // One-bit arithmetic cell
    // ------------------------------------------------------------------
    assign d = a0 ^ b0 ^ br_reg;

`ifdef ADD_MODE_EN
    logic mode_reg;

    always_comb begin
        if (mode_reg) begin
            br_next = (a0 & b0) | (br_reg & (a0 ^ b0));
        end else begin
            br_next = (~a0 & b0) | (~(a0 ^ b0) & br_reg);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_reg <= 1'b0;
        end else if (ena && start_go) begin
            mode_reg <= uio_in[3];
        end
    end
`else
    always_comb begin
        br_next = (~a0 & b0) | (~(a0 ^ b0) & br_reg);
    end
`endif

    // New difference bit enters at the MSB so the word ends up LSB-aligned after WIDTH shifts.
    generate
        if (WIDTH == 1) begin : g_res_one
            assign res_shifted = d;
        end else begin : g_res_multi
            assign res_shifted = {d, res_reg[WIDTH-1:1]};
        end
    endgenerate

    // ------------------------------------------------------------------
    // Datapath and registered status
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_reg      <= '0;
            b_reg      <= '0;
            res_reg    <= '0;
            out_reg    <= '0;
            cnt_reg    <= '0;
            br_reg     <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            borrow_reg <= 1'b0;
            zero_reg   <= 1'b0;
        end else if (ena) begin
            if (load_en) begin
                if (load_a) a_reg <= ui_in[WIDTH-1:0];
                if (load_b) b_reg <= ui_in[WIDTH-1:0];
                done_reg <= 1'b0;
            end
            if (start_go) begin
                res_reg    <= '0;
                out_reg    <= '0;
                cnt_reg    <= '0;
                br_reg     <= 1'b0;
                borrow_reg <= 1'b0;
                zero_reg   <= 1'b0;
                done_reg   <= 1'b0;
            end
            if (shift_en) begin
                a_reg   <= a_reg >> 1;
                b_reg   <= b_reg >> 1;
                res_reg <= res_shifted;
                br_reg  <= br_next;
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
            if (finish_en) begin
                out_reg    <= res_reg;
                borrow_reg <= br_reg;
                zero_reg   <= (res_reg == '0);
                done_reg   <= 1'b1;
            end
            // busy trails the SHIFT state by one edge so it aligns with done
            busy_reg <= (state_reg == SHIFT);
        end
    end

    // ------------------------------------------------------------------
    // Pin mapping
    // ------------------------------------------------------------------
    generate
        if (WIDTH < 8) begin : g_out_pad
            assign uo_out = {{(8 - WIDTH){1'b0}}, out_reg};
        end else begin : g_out_full
            assign uo_out = out_reg;
        end
    endgenerate

    assign uio_out = {zero_reg, borrow_reg, done_reg, busy_reg, 4'b0000};
    assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_serial_subtractor.sv
// Directed self-checking bench for tt_um_serial_subtractor (WIDTH=8).
// Expected values for the mode-bit vector follow ADD_MODE_EN.
module tb_tt_um_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int tests = 0;
    int fails = 0;

    tt_um_serial_subtractor #(.WIDTH(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .ui_in  (ui_in),
        .uio_in (uio_in),
        .uo_out (uo_out),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic load_ops(input logic [7:0] a, input logic [7:0] b);
        uio_in = 8'h01; ui_in = a; tick;
        uio_in = 8'h02; ui_in = b; tick;
        uio_in = 8'h00; ui_in = 8'h00;
    endtask

    // Start at edge N, optionally inject stimulus before shift edge inj_at and
    // stall ena for 3 cycles before shift edge stall_at; expect done at the end.
    task automatic run_op(input string name, input logic [7:0] start_uio,
                          input int inj_at, input logic [7:0] inj_uio, input logic [7:0] inj_ui,
                          input int stall_at,
                          input logic [7:0] exp_res, input logic exp_br, input logic exp_z);
        uio_in = start_uio; tick; uio_in = 8'h00;
        check({name, " busy@N"}, {7'b0, uio_out[4]}, 8'h00);
        for (int i = 1; i <= 8; i++) begin
            if (i == stall_at) begin
                ena = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    tick;
                    check({name, " stall busy"}, {7'b0, uio_out[4]}, 8'h01);
                    check({name, " stall done"}, {7'b0, uio_out[5]}, 8'h00);
                end
                ena = 1'b1;
            end
            if (i == inj_at) begin
                uio_in = inj_uio; ui_in = inj_ui;
            end
            tick;
            uio_in = 8'h00; ui_in = 8'h00;
            check({name, " busy"}, {7'b0, uio_out[4]}, 8'h01);
            check({name, " done early"}, {7'b0, uio_out[5]}, 8'h00);
        end
        tick;
        check({name, " done"},   {7'b0, uio_out[5]}, 8'h01);
        check({name, " busy@end"}, {7'b0, uio_out[4]}, 8'h00);
        check({name, " result"}, uo_out, exp_res);
        check({name, " borrow"}, {7'b0, uio_out[6]}, {7'b0, exp_br});
        check({name, " zero"},   {7'b0, uio_out[7]}, {7'b0, exp_z});
        check({name, " low nibble"}, {4'b0, uio_out[3:0]}, 8'h00);
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b1; ui_in = 8'h00; uio_in = 8'h00;
        tick; tick;
        check("reset uo_out", uo_out, 8'h00);
        check("reset uio_out", uio_out, 8'h00);
        check("uio_oe", uio_oe, 8'hF0);
        rst_n = 1'b1;
        tick;
        check("idle busy", {7'b0, uio_out[4]}, 8'h00);

        // Basic subtraction, underflow, equal operands
        load_ops(8'h05, 8'h03);
        run_op("5-3", 8'h04, 0, 8'h00, 8'h00, 0, 8'h02, 1'b0, 1'b0);
        tick;
        check("done held", {7'b0, uio_out[5]}, 8'h01);
        check("result held", uo_out, 8'h02);
        uio_in = 8'h01; ui_in = 8'h03; tick;
        uio_in = 8'h02; ui_in = 8'h05; tick;
        uio_in = 8'h00;
        check("load clears done", {7'b0, uio_out[5]}, 8'h00);
        check("load keeps result", uo_out, 8'h02);
        run_op("3-5", 8'h04, 0, 8'h00, 8'h00, 0, 8'hFE, 1'b1, 1'b0);
        load_ops(8'h7F, 8'h7F);
        run_op("7F-7F", 8'h04, 0, 8'h00, 8'h00, 0, 8'h00, 1'b0, 1'b1);

        // Reset during the fourth shift cycle aborts the operation
        load_ops(8'h05, 8'h03);
        uio_in = 8'h04; tick; uio_in = 8'h00;
        tick; tick; tick;
        rst_n = 1'b0; tick; rst_n = 1'b1;
        check("abort uo_out", uo_out, 8'h00);
        check("abort uio_out", uio_out, 8'h00);
        tick;
        check("abort idle", uio_out, 8'h00);
        load_ops(8'h10, 8'h01);
        run_op("10-01", 8'h04, 0, 8'h00, 8'h00, 0, 8'h0F, 1'b0, 1'b0);

        // Load+start during SHIFT is ignored
        load_ops(8'h20, 8'h05);
        run_op("inject", 8'h04, 3, 8'h05, 8'hAA, 0, 8'h1B, 1'b0, 1'b0);

        // load_b together with start in IDLE: load wins, no operation starts
        uio_in = 8'h01; ui_in = 8'h09; tick;
        uio_in = 8'h06; ui_in = 8'h04; tick;
        uio_in = 8'h00; ui_in = 8'h00;
        check("load+start busy", {7'b0, uio_out[4]}, 8'h00);
        tick;
        check("load+start busy2", {7'b0, uio_out[4]}, 8'h00);
        run_op("9-4", 8'h04, 0, 8'h00, 8'h00, 0, 8'h05, 1'b0, 1'b0);

        // ena low for 3 cycles mid-SHIFT
        load_ops(8'hC8, 8'h37);
        run_op("stall", 8'h04, 0, 8'h00, 8'h00, 4, 8'h91, 1'b0, 1'b0);

        // Mode bit: add when the feature is built in, ignored otherwise
        load_ops(8'hFF, 8'h01);
`ifdef ADD_MODE_EN
        run_op("mode", 8'h0C, 0, 8'h00, 8'h00, 0, 8'h00, 1'b1, 1'b1);
`else
        run_op("mode", 8'h0C, 0, 8'h00, 8'h00, 0, 8'hFE, 1'b0, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
